// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, parity helper and default line timing.
package ps2_pkg;

    localparam int unsigned PS2_INHIBIT_CYCLES = 5000;
    localparam int unsigned PS2_REQ_CYCLES     = 250;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 750000;
    localparam int unsigned PS2_FILTER_LEN     = 8;
    localparam int unsigned PS2_TO_W           = 20;
    localparam int unsigned PS2_BIT_W          = 4;
    localparam int unsigned PS2_LAST_FALL_IDX  = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_state_e;

    // Odd parity bit: makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pad level: 2-flop synchroniser, persistence glitch filter,
// and a one-cycle pulse on each accepted 1->0 transition.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pad;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked
// shift of data/parity/stop, acknowledge check and whole-transaction timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned REQ_CYCLES     = PS2_REQ_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_in__clk,
    input  logic       ps2_in__data,
    output logic       ps2_out__clk,
    output logic       ps2_out__data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    localparam int unsigned PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned TO_W   = PS2_TO_W;
    localparam int unsigned BIT_W  = PS2_BIT_W;

    localparam logic [PH_W-1:0]  INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0]  REQ_LAST = PH_W'(REQ_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_LAST_FALL_IDX);

    ps2_state_e       state;
    ps2_state_e       next_state;

    logic             clk_lvl;
    logic             clk_fall;
    logic             data_lvl;
    logic             unused_data_fall;

    logic [PH_W-1:0]  ph_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       shreg;
    logic             parity;
    logic             ack_bit;

    logic             accept_c;
    logic             to_hit_c;
    logic             tx_bit_c;

    logic             clk_nxt;
    logic             data_nxt;
    logic             done_nxt;
    logic             ack_nxt;
    logic             timeout_nxt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .pad   (ps2_in__clk),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .pad   (ps2_in__data),
        .level (data_lvl),
        .fall  (unused_data_fall)
    );

    assign accept_c = tx_valid && (state == ST_IDLE);
    assign to_hit_c = (state != ST_IDLE) && (to_cnt == TO_LAST);

    // Bit placed on the line at the next device clock fall: data LSB first, parity, then stop.
    always_comb begin
        tx_bit_c = 1'b1;
        if (bit_cnt < BIT_W'(8)) begin
            tx_bit_c = shreg[bit_cnt[2:0]];
        end else if (bit_cnt == BIT_W'(8)) begin
            tx_bit_c = parity;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (accept_c) next_state = ST_INHIBIT;
            ST_INHIBIT:   if (ph_cnt == INH_LAST) next_state = ST_REQ;
            ST_REQ:       if (ph_cnt == REQ_LAST) next_state = ST_SEND;
            ST_SEND:      if (clk_fall && (bit_cnt == BIT_LAST)) next_state = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (clk_lvl && data_lvl) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
        if (to_hit_c) begin
            next_state = ST_IDLE;
        end
    end

    // Next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        clk_nxt     = 1'b1;
        data_nxt    = 1'b1;
        done_nxt    = 1'b0;
        ack_nxt     = 1'b0;
        timeout_nxt = to_hit_c;
        case (next_state)
            ST_INHIBIT: clk_nxt = 1'b0;
            ST_REQ: begin
                clk_nxt  = 1'b0;
                data_nxt = 1'b0;
            end
            ST_SEND: begin
                data_nxt = ((state == ST_SEND) && clk_fall) ? tx_bit_c : ps2_out__data;
            end
            default: begin
                clk_nxt  = 1'b1;
                data_nxt = 1'b1;
            end
        endcase
        if ((state == ST_WAIT_IDLE) && (next_state == ST_IDLE) && !to_hit_c) begin
            done_nxt = 1'b1;
            ack_nxt  = ack_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_cnt  <= '0;
            to_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            ack_bit <= 1'b0;
        end else begin
            if (accept_c) begin
                shreg   <= tx_data;
                parity  <= odd_parity(tx_data);
                to_cnt  <= '0;
                bit_cnt <= '0;
                ack_bit <= 1'b0;
            end else if (state != ST_IDLE) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if ((next_state == state) && ((state == ST_INHIBIT) || (state == ST_REQ))) begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end else begin
                ph_cnt <= '0;
            end

            // Device clock falls only advance the shifter while sending.
            if ((state == ST_SEND) && clk_fall) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                if (bit_cnt == BIT_LAST) begin
                    ack_bit <= ~data_lvl;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_out__clk  <= 1'b1;
            ps2_out__data <= 1'b1;
            tx_ready      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            ack_ok        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            ps2_out__clk  <= clk_nxt;
            ps2_out__data <= data_nxt;
            tx_ready      <= (next_state == ST_IDLE);
            busy          <= (next_state != ST_IDLE);
            done          <= done_nxt;
            ack_ok        <= ack_nxt;
            timeout       <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 5000;
    localparam int unsigned REQ  = 250;
    localparam int unsigned TMO  = 12000;
    localparam int unsigned FLT  = 8;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_out__clk;
    logic       ps2_out__data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       timeout;

    logic       dev_clk;
    logic       dev_data;
    logic       pad_clk;
    logic       pad_data;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;
    int         to_seen  = 0;
    int         both_cnt = 0;
    logic       last_ack = 1'b0;

    assign pad_clk  = ps2_out__clk & dev_clk;
    assign pad_data = ps2_out__data & dev_data;

    always #10 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_in__clk   (pad_clk),
        .ps2_in__data  (pad_data),
        .ps2_out__clk  (ps2_out__clk),
        .ps2_out__data (ps2_out__data),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done),
        .ack_ok        (ack_ok),
        .timeout       (timeout)
    );

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_ack = ack_ok;
        end
        if (timeout === 1'b1) to_seen = to_seen + 1;
        if ((done === 1'b1) && (timeout === 1'b1)) both_cnt = both_cnt + 1;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got 90000 cycles required fewer");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One device clock period; the device samples the host's data just before its rising edge.
    task automatic dev_bit(input logic glitch, output logic smp);
        if (glitch) begin
            wait_cyc(HALF / 2);
            dev_clk = 1'b0;
            wait_cyc(3);
            dev_clk = 1'b1;
            wait_cyc(HALF - HALF / 2 - 3);
        end else begin
            wait_cyc(HALF);
        end
        dev_clk = 1'b0;
        wait_cyc(HALF);
        smp = pad_data;
        dev_clk = 1'b1;
    endtask

    task automatic do_xfer(input string nm, input logic [7:0] b, input logic exp_par,
                           input logic ack, input logic glitch, input logic poke);
        int          inh;
        int          req;
        int          k;
        int          d0;
        logic [10:0] bits;
        logic        smp;
        check({nm, "_ready_pre"}, 32'(tx_ready), 32'd1);
        d0 = done_cnt;
        tx_valid = 1'b1;
        tx_data  = b;
        wait_cyc(1);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check({nm, "_clk_low_n1"}, 32'(ps2_out__clk), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd1);
        inh = 0;
        while ((ps2_out__clk === 1'b0) && (ps2_out__data === 1'b1) && (inh < int'(INH) + 100)) begin
            if (poke && (inh == 2)) begin
                tx_valid = 1'b1;
                tx_data  = ~b;
            end
            if (poke && (inh == 4)) tx_valid = 1'b0;
            inh++;
            wait_cyc(1);
        end
        req = 0;
        while ((ps2_out__clk === 1'b0) && (ps2_out__data === 1'b0) && (req < int'(REQ) + 100)) begin
            req++;
            wait_cyc(1);
        end
        check({nm, "_inhibit_len"}, 32'(inh), 32'(INH));
        check({nm, "_req_len"}, 32'(req), 32'(REQ));
        check({nm, "_start_clk"}, 32'(ps2_out__clk), 32'd1);
        check({nm, "_start_data"}, 32'(ps2_out__data), 32'd0);
        for (int i = 0; i < 11; i++) begin
            if ((i == 10) && ack) dev_data = 1'b0;
            dev_bit(glitch && (i == 4), smp);
            bits[i] = smp;
        end
        wait_cyc(HALF);
        dev_data = 1'b1;
        k = 0;
        while ((done_cnt == d0) && (k < 500)) begin
            wait_cyc(1);
            k++;
        end
        check({nm, "_byte"}, 32'(bits[7:0]), 32'(b));
        check({nm, "_parity"}, 32'(bits[8]), 32'(exp_par));
        check({nm, "_stop"}, 32'(bits[9]), 32'd1);
        check({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({nm, "_ack_ok"}, 32'(last_ack), 32'(ack));
        check({nm, "_ready_post"}, 32'(tx_ready), 32'd1);
        check({nm, "_busy_post"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   k;
        int   d0;
        int   t0;
        logic smp;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_cyc(3);
        check("rst_clk", 32'(ps2_out__clk), 32'd1);
        check("rst_data", 32'(ps2_out__data), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack", 32'(ack_ok), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        wait_cyc(20);

        do_xfer("ed", 8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
        do_xfer("ff", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        do_xfer("x01", 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
        do_xfer("noack", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        do_xfer("glitch", 8'h96, 1'b1, 1'b1, 1'b1, 1'b0);

        // Device never clocks: the transaction must abort on the timeout.
        d0 = done_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        wait_cyc(1);
        tx_valid = 1'b0;
        k = 1;
        while ((timeout !== 1'b1) && (k < int'(TMO) + 100)) begin
            wait_cyc(1);
            k++;
        end
        check("to_latency", 32'(k), 32'(TMO + 1));
        check("to_clk", 32'(ps2_out__clk), 32'd1);
        check("to_data", 32'(ps2_out__data), 32'd1);
        wait_cyc(1);
        check("to_clk_next", 32'(ps2_out__clk), 32'd1);
        check("to_data_next", 32'(ps2_out__data), 32'd1);
        check("to_pulse_width", 32'(timeout), 32'd0);
        check("to_ready", 32'(tx_ready), 32'd1);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        wait_cyc(20);

        // Reset in the middle of the data bits.
        d0 = done_cnt;
        t0 = to_seen;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        wait_cyc(1);
        tx_valid = 1'b0;
        k = 0;
        while ((ps2_out__clk !== 1'b1) && (k < int'(INH + REQ) + 100)) begin
            wait_cyc(1);
            k++;
        end
        check("rm_reached_send", 32'(ps2_out__clk), 32'd1);
        for (int i = 0; i < 4; i++) dev_bit(1'b0, smp);
        dev_clk = 1'b0;
        wait_cyc(HALF / 2);
        check("rm_pre_data_bit3", 32'(ps2_out__data), 32'd0);
        check("rm_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        wait_cyc(1);
        check("rm_clk", 32'(ps2_out__clk), 32'd1);
        check("rm_data", 32'(ps2_out__data), 32'd1);
        check("rm_ready", 32'(tx_ready), 32'd1);
        check("rm_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_cyc(HALF / 2);
        dev_clk = 1'b1;
        wait_cyc(300);
        check("rm_no_done", 32'(done_cnt - d0), 32'd0);
        check("rm_no_timeout", 32'(to_seen - t0), 32'd0);
        check("rm_ready_after", 32'(tx_ready), 32'd1);

        check("done_timeout_overlap", 32'(both_cnt), 32'd0);
        check("total_timeouts", 32'(to_seen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
